// File: rtl/ps2_pkg.sv
// PS/2 device transmitter shared definitions.
// State encoding, frame length and timing helpers.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        BUSWAIT = 3'd1,
        HIGH    = 3'd2,
        LOW     = 3'd3,
        HOLD    = 3'd4
    } ps2_state_t;

    localparam int FRAME_BITS = 11;

    function automatic int us_to_cycles(
        input int clk_hz,
        input int us
    );
        return clk_hz / 1000000 * us;
    endfunction

    // Frame bit by index: start, data LSB first, odd parity, stop.
    function automatic logic frame_bit(
        input logic [7:0] data,
        input logic [3:0] idx
    );
        logic [10:0] f;
        f = {1'b1, ~^data, data, 1'b0};
        return f[idx];
    endfunction

endpackage

// File: rtl/ps2_device_tx_sync2.sv
// Two-flop synchroniser for a sensed PS/2 line.
// Resets to 1 so a released bus reads idle.
module ps2_sync2
    import ps2_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] ff_q;

    // Shift the asynchronous line through two flops.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ff_q <= 2'b11;
        end else begin
            ff_q <= {ff_q[0], d_i};
        end
    end

    assign q_o = ff_q[1];

endmodule

// File: rtl/ps2_device_tx.sv
// PS/2 device-side transmitter: sends one 11-bit frame per
// accepted byte, generating the clock and retrying on inhibit.
module ps2_device_tx
    import ps2_pkg::*;
#(
    parameter int CLK_HZ  = 50000000,
    parameter int HALF_US = 40,
    parameter int IDLE_US = 50
) (
    input  logic       clk_chipset,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_abort
);

    localparam int HALF_CNT = us_to_cycles(CLK_HZ, HALF_US);
    localparam int IDLE_CNT = us_to_cycles(CLK_HZ, IDLE_US);
    localparam int MAX_CNT  =
        (HALF_CNT > IDLE_CNT) ? HALF_CNT : IDLE_CNT;
    localparam int CW = $clog2(MAX_CNT) + 1;

    localparam logic [CW-1:0] HALF_LAST   = CW'(HALF_CNT - 1);
    localparam logic [CW-1:0] IDLE_LAST   = CW'(IDLE_CNT - 1);
    localparam logic [CW-1:0] INHIBIT_MIN = CW'(2);
    localparam logic [3:0]    STOP_IDX    = 4'(FRAME_BITS - 1);

    logic clk_s;
    logic data_s;

    ps2_sync2 u_sync_clk (
        .clk_i (clk_chipset),
        .rst_i (reset),
        .d_i   (ps2_clk_i),
        .q_o   (clk_s)
    );

    ps2_sync2 u_sync_data (
        .clk_i (clk_chipset),
        .rst_i (reset),
        .d_i   (ps2_data_i),
        .q_o   (data_s)
    );

    ps2_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    bit_q, bit_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          clk_oe_q, clk_oe_d;
    logic          data_oe_q, data_oe_d;
    logic          ready_q, ready_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          abort_q, abort_d;

    logic phase_end;
    logic bus_idle;
    logic inhibit;

    assign phase_end = (cnt_q == HALF_LAST);
    assign bus_idle  = clk_s & data_s;
    // The first two HIGH cycles still see our own low clock
    // through the synchroniser, so they are not trusted.
    assign inhibit   = ~clk_s
                     & (bit_q != STOP_IDX)
                     & (cnt_q >= INHIBIT_MIN);

    // Next-state logic for the frame sequencer.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        shreg_d   = shreg_q;
        clk_oe_d  = clk_oe_q;
        data_oe_d = data_oe_q;
        ready_d   = ready_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        abort_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (tx_valid && ready_q) begin
                    shreg_d = tx_data;
                    ready_d = 1'b0;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = BUSWAIT;
                end
            end

            BUSWAIT: begin
                if (!bus_idle) begin
                    cnt_d = '0;
                end else if (cnt_q == IDLE_LAST) begin
                    cnt_d     = '0;
                    bit_d     = 4'd0;
                    data_oe_d = ~frame_bit(shreg_q, 4'd0);
                    state_d   = HIGH;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            HIGH: begin
                if (inhibit) begin
                    clk_oe_d  = 1'b0;
                    data_oe_d = 1'b0;
                    abort_d   = 1'b1;
                    bit_d     = 4'd0;
                    cnt_d     = '0;
                    state_d   = BUSWAIT;
                end else if (phase_end) begin
                    clk_oe_d = 1'b1;
                    cnt_d    = '0;
                    state_d  = LOW;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            LOW: begin
                if (phase_end) begin
                    clk_oe_d = 1'b0;
                    cnt_d    = '0;
                    if (bit_q != STOP_IDX) begin
                        bit_d     = bit_q + 4'd1;
                        data_oe_d =
                            ~frame_bit(shreg_q, bit_q + 4'd1);
                        state_d   = HIGH;
                    end else begin
                        data_oe_d = 1'b0;
                        state_d   = HOLD;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            HOLD: begin
                if (phase_end) begin
                    done_d  = 1'b1;
                    ready_d = 1'b1;
                    busy_d  = 1'b0;
                    bit_d   = 4'd0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                ready_d   = 1'b1;
                busy_d    = 1'b0;
                bit_d     = 4'd0;
                cnt_d     = '0;
                state_d   = IDLE;
            end
        endcase
    end

    // Sequencer registers; reset releases both lines at once.
    always_ff @(posedge clk_chipset or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_q     <= 4'd0;
            shreg_q   <= 8'd0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            abort_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shreg_q   <= shreg_d;
            clk_oe_q  <= clk_oe_d;
            data_oe_q <= data_oe_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            abort_q   <= abort_d;
        end
    end

    assign tx_ready    = ready_q;
    assign busy        = busy_q;
    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;
    assign tx_done     = done_q;
    assign tx_abort    = abort_q;

endmodule

// File: tb/tb_ps2_device_tx.sv
// Bench for ps2_device_tx: a host-side line model decodes
// frames at falling clock edges and compares them to the byte.
module tb_ps2_device_tx;

    localparam int CLK_HZ   = 1000000;
    localparam int HALF_US  = 4;
    localparam int IDLE_US  = 8;
    localparam int HALF_CNT = CLK_HZ / 1000000 * HALF_US;
    localparam int IDLE_CNT = CLK_HZ / 1000000 * IDLE_US;
    localparam int SYNC_LAT = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] tx_data = 8'd0;
    logic       tx_valid = 1'b0;
    logic       host_clk_low = 1'b0;
    logic       tx_ready;
    logic       ps2_clk_i;
    logic       ps2_data_i;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;
    logic       busy;
    logic       tx_done;
    logic       tx_abort;

    assign ps2_clk_i  = ~(ps2_clk_oe | host_clk_low);
    assign ps2_data_i = ~ps2_data_oe;

    ps2_device_tx #(
        .CLK_HZ  (CLK_HZ),
        .HALF_US (HALF_US),
        .IDLE_US (IDLE_US)
    ) dut (
        .clk_chipset (clk),
        .reset       (reset),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .ps2_clk_i   (ps2_clk_i),
        .ps2_data_i  (ps2_data_i),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .busy        (busy),
        .tx_done     (tx_done),
        .tx_abort    (tx_abort)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic        q[$];
    int          falls = 0;
    int          done_cnt = 0;
    int          abort_cnt = 0;
    int          both_cnt = 0;
    int          last_rise = 0;
    int          done_cyc = 0;
    int          nbits = 0;
    logic [10:0] frame_v = '0;
    logic        prev_clk_oe = 1'b0;
    logic        abort_oe = 1'b1;

    // Host-side view: sample data on each falling clock edge.
    always @(negedge clk) begin
        if (reset) begin
            q.delete();
            falls = 0;
            prev_clk_oe = 1'b0;
        end else begin
            if (ps2_clk_oe && !prev_clk_oe) begin
                q.push_back(ps2_data_i);
                falls++;
            end
            if (!ps2_clk_oe && prev_clk_oe) last_rise = cyc;
            if (tx_done && tx_abort) both_cnt++;
            if (tx_done) begin
                done_cnt++;
                done_cyc = cyc;
                nbits = q.size();
                frame_v = '0;
                foreach (q[i]) if (i < 11) frame_v[i] = q[i];
                q.delete();
                falls = 0;
            end
            if (tx_abort) begin
                abort_cnt++;
                abort_oe = ps2_clk_oe | ps2_data_oe;
                q.delete();
                falls = 0;
            end
            prev_clk_oe = ps2_clk_oe;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h",
                   tag, obs, exp);
        end
    endtask

    function automatic logic [10:0] exp_frame(input logic [7:0] b);
        int ones;
        logic [10:0] v;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        v[0]   = 1'b0;
        v[8:1] = b;
        v[9]   = (ones % 2 == 0);
        v[10]  = 1'b1;
        return v;
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        tick();
        tx_data  = b;
        tx_valid = 1'b1;
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        chk("accept_busy", busy, 1);
        chk("accept_ready", tx_ready, 0);
    endtask

    task automatic measure(output int nd, output int nc);
        nd = -1;
        nc = -1;
        for (int i = 1; i <= 80; i++) begin
            @(posedge clk);
            #1;
            if (nd < 0 && ps2_data_oe) nd = i;
            if (ps2_clk_oe) begin
                nc = i;
                break;
            end
        end
    endtask

    task automatic wait_done(input int bound);
        int d0;
        logic leak;
        d0 = done_cnt;
        leak = 1'b0;
        for (int i = 0; i < bound; i++) begin
            tick();
            if (done_cnt != d0) break;
            if (tx_ready) leak = 1'b1;
        end
        chk("done_seen", done_cnt, d0 + 1);
        chk("ready_low_in_frame", leak, 0);
        chk("ready_at_done", tx_ready, 1);
        chk("busy_at_done", busy, 0);
    endtask

    task automatic check_frame(input logic [7:0] b);
        chk("frame_bits", nbits, 11);
        chk("frame_value", frame_v, exp_frame(b));
        chk("done_latency", done_cyc - last_rise, HALF_CNT);
    endtask

    task automatic wait_phase(input int n, input logic oe);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (falls == n && ps2_clk_oe == oe) begin
                hit = 1'b1;
                break;
            end
        end
        chk("reach_phase", hit, 1);
    endtask

    task automatic abort_run(input logic [7:0] b, input int n);
        int a0;
        int d0;
        a0 = abort_cnt;
        d0 = done_cnt;
        send(b);
        wait_phase(n, 1'b0);
        host_clk_low = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (abort_cnt != a0) break;
            tick();
        end
        chk("abort_pulse", abort_cnt, a0 + 1);
        chk("abort_lines_released", abort_oe, 0);
        chk("abort_busy", busy, 1);
        repeat (10) tick();
        host_clk_low = 1'b0;
        wait_done(600);
        check_frame(b);
        chk("abort_single", abort_cnt, a0 + 1);
        chk("abort_one_done", done_cnt, d0 + 1);
    endtask

    int nd;
    int nc;
    int a0;
    int d0;
    logic [7:0] rb;

    initial begin
        reset = 1'b1;
        repeat (3) @(posedge clk);
        tick();
        chk("rst_ready", tx_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_oe", {ps2_clk_oe, ps2_data_oe}, 0);
        chk("rst_pulses", {tx_done, tx_abort}, 0);
        reset = 1'b0;
        tick();

        send(8'h1C);
        measure(nd, nc);
        chk("t1_first_data", nd, IDLE_CNT);
        chk("t1_first_clk", nc, IDLE_CNT + HALF_CNT);
        wait_done(300);
        check_frame(8'h1C);

        send(8'h00);
        repeat (20) tick();
        tx_data  = 8'hFF;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        d0 = done_cnt;
        wait_done(300);
        check_frame(8'h00);
        repeat (60) tick();
        chk("t2_no_extra_frame", done_cnt, d0 + 1);
        chk("t2_idle_busy", busy, 0);

        a0 = abort_cnt;
        host_clk_low = 1'b1;
        repeat (20) tick();
        send(8'hA5);
        repeat (5) tick();
        chk("t3_stalled", {ps2_clk_oe, ps2_data_oe}, 0);
        host_clk_low = 1'b0;
        measure(nd, nc);
        chk("t3_first_data", nd, IDLE_CNT + SYNC_LAT);
        chk("t3_first_clk", nc, IDLE_CNT + SYNC_LAT + HALF_CNT);
        wait_done(300);
        check_frame(8'hA5);
        chk("t3_no_abort", abort_cnt, a0);

        abort_run(8'h1C, 3);
        abort_run(8'h1C, 1);
        rb = 8'($urandom);
        abort_run(rb, int'($urandom_range(1, 9)));

        a0 = abort_cnt;
        send(8'h1C);
        wait_phase(10, 1'b0);
        host_clk_low = 1'b1;
        repeat (6) tick();
        host_clk_low = 1'b0;
        wait_done(300);
        check_frame(8'h1C);
        chk("t5_no_abort", abort_cnt, a0);

        for (int k = 0; k < 4; k++) begin
            rb = 8'($urandom);
            send(rb);
            wait_done(300);
            check_frame(rb);
        end

        a0 = abort_cnt;
        d0 = done_cnt;
        send(8'hE3);
        wait_phase(6, 1'b1);
        chk("t6_pre_oe", {ps2_clk_oe, ps2_data_oe}, 2'b11);
        reset = 1'b1;
        #1;
        chk("t6_rst_oe", {ps2_clk_oe, ps2_data_oe}, 0);
        chk("t6_rst_ready", tx_ready, 1);
        chk("t6_rst_busy", busy, 0);
        tick();
        reset = 1'b0;
        repeat (80) tick();
        chk("t6_no_done", done_cnt, d0);
        chk("t6_no_abort", abort_cnt, a0);
        chk("t6_quiet", falls, 0);
        chk("t6_idle_oe", {ps2_clk_oe, ps2_data_oe}, 0);

        chk("done_abort_overlap", both_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_device_tx.md
Name: ps2_device_tx

Overview:
- PS/2 device-side transmitter: serialises scancode bytes onto an open-collector PS/2 clock/data pair and generates the PS/2 clock itself.
- It is the other end of the keyboard receiver in `system` that listens on `clkps2`/`dataps2`.
- Used by the joystick-to-keyboard bridge and by loopback self-test.
- Sits in the `clk_chipset` (50 MHz) domain; line drivers are implemented outside this block as `oe ? 1'b0 : 1'bz`.

Parameters:
- CLK_HZ, 50000000, frequency of `clk_chipset` in Hz.
- HALF_US, 40, PS2 clock half-period in µs. HALF_CNT = CLK_HZ/1000000*HALF_US, which is 2000 at the defaults.
- IDLE_US, 50, time both lines must read high before a frame starts. IDLE_CNT = CLK_HZ/1000000*IDLE_US.

Ports:
- clk_chipset  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- tx_data  in  8  byte to send.
- tx_valid  in  1  tx_data is valid.
- tx_ready  out  1  block can accept a byte.
- ps2_clk_i  in  1  sensed PS2 clock line (asynchronous).
- ps2_data_i  in  1  sensed PS2 data line (asynchronous).
- ps2_clk_oe  out  1  1 = pull clock line low.
- ps2_data_oe  out  1  1 = pull data line low.
- busy  out  1  frame pending or in progress.
- tx_done  out  1  one-cycle pulse when a frame completes.
- tx_abort  out  1  one-cycle pulse when the host aborts a frame.

Behaviour:
- Reset values: tx_ready=1; ps2_clk_oe=0, ps2_data_oe=0, busy=0, tx_done=0, tx_abort=0; FSM in IDLE; all counters 0; both synchronisers preset to 1.
- Reset mid-frame releases both lines immediately (asynchronous) and discards the pending byte.
- Synchronisers: ps2_clk_i and ps2_data_i each pass through 2 flops, giving clk_s/data_s. All line sensing uses only clk_s/data_s.
- Accept: byte latched into shreg when tx_valid & tx_ready. From the next cycle, tx_ready=0 and busy=1 until tx_done. tx_valid is ignored while tx_ready=0.
- Frame is 11 bits: start 0, data[0..7] LSB first, odd parity = ~^data, stop 1. Bit index runs 0..10.
- FSM states:
  - IDLE: waiting for a byte.
  - BUSWAIT: counts consecutive cycles with clk_s=1 and data_s=1; any low sample clears the count. Reaching IDLE_CNT moves to HIGH with bit=0.
  - HIGH: clock released. On entry, ps2_data_oe = ~bit_value. Held for HALF_CNT cycles, then moves to LOW.
  - LOW: ps2_clk_oe=1 for HALF_CNT cycles. Then: if bit<10, bit++ and go to HIGH; if bit=10, go to HOLD.
  - HOLD: both lines released for HALF_CNT cycles, then tx_done pulse, tx_ready=1, busy=0, go to IDLE.
- The host samples on the falling clock edge, i.e. each bit is stable for a full HALF_CNT before its falling edge.
- Abort: in HIGH for bits 0..9, from the 3rd cycle of the phase onward (covers synchroniser lag), clk_s=0 means the host is inhibiting. Response on the same cycle:
  - release both lines;
  - pulse tx_abort;
  - go to BUSWAIT with bit=0 and shreg retained, so the frame retransmits automatically once the bus is idle;
  - busy stays 1.
- Once bit index is 10 (stop), host clock-low is ignored and the frame completes.
- A clock held low at accept time just stalls BUSWAIT, with no abort pulse.
- tx_done and tx_abort never assert in the same cycle.
- Counters: width $clog2(max(HALF_CNT,IDLE_CNT))+1. A phase counter reloads on every state change.

Decomposition:
- Package ps2_pkg holds:
  - the state enum {IDLE, BUSWAIT, HIGH, LOW, HOLD};
  - FRAME_BITS=11;
  - the function us_to_cycles(clk_hz, us).
- One sub-module, ps2_sync2: 2-flop synchroniser with a preset-to-1 async reset, instantiated twice.

Test Plan:
All scenarios use CLK_HZ=1000000, HALF_US=4, IDLE_US=8, giving HALF_CNT=4 and IDLE_CNT=8.
1. Send 0x1C with idle lines → lines released for 8 cycles; then the data line sampled at falling edges reads 0,0,0,1,1,1,0,0,0,0,1 (start, LSB first, parity 0, stop 1); exactly 11 falling edges; tx_done 4 cycles after the last rising edge.
2. Send 0x00 → parity bit = 1; tx_ready low from accept+1 until tx_done; second tx_valid during the frame is ignored.
3. Host holds ps2_clk_i low for 20 cycles before accept → no clock/data activity until 8 idle cycles after release; no tx_abort.
4. Host pulls clock low during the HIGH phase of bit 3 → tx_abort pulse; both oe=0 the same cycle; after the bus is idle for 8 cycles, full frame 0x1C is retransmitted; a single tx_done.
5. Host pulls clock low during the stop-bit HIGH phase → no abort; tx_done still pulses.
6. Assert reset in the LOW phase of bit 5 → ps2_clk_oe=0 and ps2_data_oe=0 immediately; tx_ready=1, busy=0; no tx_done or tx_abort after release.
